alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Single-issue sequencer in front of the `alu` instance in the data-processing path.
- Accepts one data-processing request at a time over a valid/ready handshake and evaluates its ARM condition code against an internal NZCV register.
- Drives the ALU, captures the result, updates NZCV per the S bit and opcode class, then presents a writeback response under valid/ready backpressure.

Parameters:
- FLAGS_RESET, 4'b0000, NZCV value loaded on reset (bit0 N, bit1 Z, bit2 C, bit3 V).

Ports:
- clk  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (high only in IDLE)
- req_op  in  5  ALU opcode (AND 0, EOR 1, SUB 2, RSB 3, ADD 4, TST 8, TEQ 9, CMP A, CMN B, ORR C)
- req_cond  in  4  ARM condition field
- req_s  in  1  set-flags bit
- req_rd  in  4  destination register index
- req_a  in  32  operand A
- req_b  in  32  operand B
- alu_a, alu_b  out  32  operands to ALU
- alu_opcode  out  5  opcode to ALU
- alu_c  in  32  ALU result
- alu_flags  in  4  ALU NZCV (same bit order)
- wb_valid  out  1  response valid
- wb_ready  in  1  consumer accepts response
- wb_rd  out  4  destination index
- wb_data  out  32  result
- wb_we  out  1  write rd (condition passed, non-compare, supported)
- wb_executed  out  1  condition passed
- wb_err  out  1  unsupported opcode
- flags  out  4  current NZCV register

Behaviour:
- Reset: state IDLE; flags=FLAGS_RESET; wb_valid, wb_we, wb_executed, wb_err=0; wb_data=0; wb_rd=0; alu_a/alu_b/alu_opcode=0. Reset mid-operation aborts the in-flight request with no flag update and no response.
- States: IDLE -> EXEC -> RESP -> IDLE.
- IDLE: req_ready=1. On req_valid, latch op, cond, s, rd, a, b and go to EXEC. Otherwise stay.
- EXEC, one cycle:
  - Drive latched a/b/op to the ALU; the ALU is combinational.
  - Capture alu_c and alu_flags; evaluate the condition against the current flags.
  - Go to RESP.
- RESP: wb_valid=1; all wb_* fields are stable until the wb_valid&wb_ready edge, then go to IDLE.
- Latency and throughput: accept at edge T, wb_valid high from T+2; minimum 3 cycles per request; no overlap.
- Condition pass (flags as they stand at EXEC):
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1; NV (F) 0.
- Flag update, registered at the EXEC edge, only if the condition passes and the op is supported:
  - Compare ops TST/TEQ/CMP/CMN always update flags (S ignored) and never write rd.
  - Arithmetic SUB/RSB/ADD update all four NZCV bits when req_s=1.
  - Logical AND/EOR/ORR/TST/TEQ update N and Z only; C and V are retained.
- Unsupported opcode (5-7, D, E, >=0x0D): wb_err=1, wb_we=0, no flag change. wb_executed still reflects the condition.
- Condition fail: wb_we=0, wb_executed=0, flags unchanged. wb_data still carries alu_c.
- wb_data is alu_c as captured in EXEC.

Optional Feature:
- Macro ALU_ISSUE_OUTREG_EN.
- Defined:
  - Adds an ALU_WAIT state between EXEC and RESP.
  - ALU outputs are registered in EXEC; capture, condition and flag update occur in ALU_WAIT.
  - Latency is wb_valid from T+3; minimum 4 cycles per request.
- Undefined: behaviour as above.

Decomposition:
- Package alu_pkg:
  - opcode constants;
  - NEG/ZER/CAR/OVR bit indices;
  - 4-bit condition-code constants;
  - typedef for the state enum;
  - typedef for the latched request struct.
- One combinational sub-module, cond_eval (cond[3:0], nzcv[3:0] -> pass).

Test Plan:
- ADD, AL, S=1, a=0x7FFFFFFF, b=1, flags=0 -> wb_data=0x80000000, wb_we=1, flags=4'b1001 at T+2.
- CMP, AL, a=5, b=5 -> wb_we=0, wb_executed=1, flags=4'b0110. Then SUB EQ a=9 b=4 -> wb_data=5, wb_we=1. Then ADD NE -> wb_executed=0, wb_we=0, flags still 4'b0110.
- flags=4'b0100 (C=1); AND, S=1, a=0xF0, b=0x0F -> wb_data=0, flags=4'b0110 (C retained, Z set).
- req_op=5 (ADC) -> wb_err=1, wb_we=0, flags unchanged.
- Hold wb_ready=0 for 4 cycles in RESP -> wb_valid and wb_* stable, req_ready=0; release -> IDLE the next cycle, req_ready=1.
- Assert reset during EXEC -> next cycle IDLE, wb_valid=0, flags=FLAGS_RESET, no response ever emitted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit indices, condition codes, FSM state and latched-request types.
// Used by alu_issue_ctrl; the ALU_WAIT state exists only when ALU_ISSUE_OUTREG_EN is defined.
package alu_pkg;

  localparam logic [4:0] OP_AND = 5'h00;
  localparam logic [4:0] OP_EOR = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_RSB = 5'h03;
  localparam logic [4:0] OP_ADD = 5'h04;
  localparam logic [4:0] OP_TST = 5'h08;
  localparam logic [4:0] OP_TEQ = 5'h09;
  localparam logic [4:0] OP_CMP = 5'h0A;
  localparam logic [4:0] OP_CMN = 5'h0B;
  localparam logic [4:0] OP_ORR = 5'h0C;

  localparam int NEG = 0;
  localparam int ZER = 1;
  localparam int CAR = 2;
  localparam int OVR = 3;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

`ifdef ALU_ISSUE_OUTREG_EN
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_ALU_WAIT = 2'd2,
    ST_RESP     = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;
`endif

  typedef struct packed {
    logic [4:0]  op;
    logic [3:0]  cond;
    logic        s;
    logic [3:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
  } req_t;

  function automatic logic op_supported(input logic [4:0] op);
    case (op)
      OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD,
      OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_compare(input logic [4:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  // Arithmetic class owns C and V; logical ops only ever touch N and Z.
  function automatic logic op_is_arith(input logic [4:0] op);
    return (op == OP_SUB) || (op == OP_RSB) || (op == OP_ADD) ||
           (op == OP_CMP) || (op == OP_CMN);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_cond_eval.sv
// Combinational ARM condition-code evaluator: cond + NZCV -> pass, zero latency.
// No handshake; output follows inputs directly.
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n, z, c, v;

  assign n = nzcv[NEG];
  assign z = nzcv[ZER];
  assign c = nzcv[CAR];
  assign v = nzcv[OVR];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-issue ALU sequencer: accept -> EXEC -> RESP, wb_valid two cycles after accept (three with
// ALU_ISSUE_OUTREG_EN); req_ready only in IDLE, response held stable until wb_valid & wb_ready.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [3:0]  req_cond,
  input  logic        req_s,
  input  logic [3:0]  req_rd,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_opcode,
  input  logic [31:0] alu_c,
  input  logic [3:0]  alu_flags,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic        wb_executed,
  output logic        wb_err,
  output logic [3:0]  flags
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic [3:0]  flags_q, flags_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [3:0]  wb_rd_q, wb_rd_d;
  logic        wb_we_q, wb_we_d;
  logic        wb_executed_q, wb_executed_d;
  logic        wb_err_q, wb_err_d;

  logic [31:0] res_c;
  logic [3:0]  res_flags;
  logic        capture;
  logic        cond_pass;
  logic        supported;
  logic        compare;
  logic        upd_nz;
  logic        upd_all;

  cond_eval u_cond_eval (
    .cond (req_q.cond),
    .nzcv (flags_q),
    .pass (cond_pass)
  );

`ifdef ALU_ISSUE_OUTREG_EN
  logic [31:0] alu_c_q, alu_c_d;
  logic [3:0]  alu_flags_q, alu_flags_d;

  always_comb begin
    alu_c_d     = alu_c_q;
    alu_flags_d = alu_flags_q;
    if (state_q == ST_EXEC) begin
      alu_c_d     = alu_c;
      alu_flags_d = alu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_c_q     <= '0;
      alu_flags_q <= '0;
    end else begin
      alu_c_q     <= alu_c_d;
      alu_flags_q <= alu_flags_d;
    end
  end

  assign res_c     = alu_c_q;
  assign res_flags = alu_flags_q;
  assign capture   = (state_q == ST_ALU_WAIT);
`else
  assign res_c     = alu_c;
  assign res_flags = alu_flags;
  assign capture   = (state_q == ST_EXEC);
`endif

  assign supported = op_supported(req_q.op);
  assign compare   = op_is_compare(req_q.op);
  // Compares set flags regardless of S; arithmetic class additionally owns C/V.
  assign upd_nz    = cond_pass && supported && (compare || req_q.s);
  assign upd_all   = upd_nz && op_is_arith(req_q.op);

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    flags_d       = flags_q;
    wb_data_d     = wb_data_q;
    wb_rd_d       = wb_rd_q;
    wb_we_d       = wb_we_q;
    wb_executed_d = wb_executed_q;
    wb_err_d      = wb_err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d.op   = req_op;
          req_d.cond = req_cond;
          req_d.s    = req_s;
          req_d.rd   = req_rd;
          req_d.a    = req_a;
          req_d.b    = req_b;
          state_d    = ST_EXEC;
        end
      end
`ifdef ALU_ISSUE_OUTREG_EN
      ST_EXEC:     state_d = ST_ALU_WAIT;
      ST_ALU_WAIT: state_d = ST_RESP;
`else
      ST_EXEC:     state_d = ST_RESP;
`endif
      ST_RESP: begin
        if (wb_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (capture) begin
      wb_data_d     = res_c;
      wb_rd_d       = req_q.rd;
      wb_err_d      = !supported;
      wb_executed_d = cond_pass;
      wb_we_d       = cond_pass && supported && !compare;
      if (upd_nz) begin
        flags_d[NEG] = res_flags[NEG];
        flags_d[ZER] = res_flags[ZER];
      end
      if (upd_all) begin
        flags_d[CAR] = res_flags[CAR];
        flags_d[OVR] = res_flags[OVR];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      flags_q       <= FLAGS_RESET;
      wb_data_q     <= '0;
      wb_rd_q       <= '0;
      wb_we_q       <= 1'b0;
      wb_executed_q <= 1'b0;
      wb_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      flags_q       <= flags_d;
      wb_data_q     <= wb_data_d;
      wb_rd_q       <= wb_rd_d;
      wb_we_q       <= wb_we_d;
      wb_executed_q <= wb_executed_d;
      wb_err_q      <= wb_err_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign wb_valid    = (state_q == ST_RESP);
  assign alu_a       = req_q.a;
  assign alu_b       = req_q.b;
  assign alu_opcode  = req_q.op;
  assign wb_data     = wb_data_q;
  assign wb_rd       = wb_rd_q;
  assign wb_we       = wb_we_q;
  assign wb_executed = wb_executed_q;
  assign wb_err      = wb_err_q;
  assign flags       = flags_q;

endmodule
